// File: rtl/uart_baud_nco_if.sv
// uart_baud_nco_if -- control/tick bundle between a UART engine and its
// baud-tick generator.
//
// Signals:
//   en        run enable (engine -> generator)
//   restart   synchronous realign pulse, e.g. RX start-bit detect
//   baud_rate requested rate in baud (17 bits)
//   os_tick   one-cycle pulse at OVERSAMPLE x baud
//   mid_tick  one-cycle pulse at bit centre
//   bit_tick  one-cycle pulse at bit end
//   rate_err  high while baud_rate is not a supported rate
//
// Modports: master = UART engine side, slave = tick generator side.
interface uart_baud_nco_if;
   logic        en;
   logic        restart;
   logic [16:0] baud_rate;
   logic        os_tick;
   logic        mid_tick;
   logic        bit_tick;
   logic        rate_err;

   modport master (
      output en, restart, baud_rate,
      input  os_tick, mid_tick, bit_tick, rate_err
   );

   modport slave (
      input  en, restart, baud_rate,
      output os_tick, mid_tick, bit_tick, rate_err
   );
endinterface

// File: rtl/uart_baud_nco.sv
// uart_baud_nco -- UART baud-tick generator.
//
// Produces an oversampling tick, a mid-bit sample strobe and a bit-boundary
// strobe for the standard rates 1200..115200 baud at any system clock.
// Unsupported rates run at 9600 baud and raise rate_err.
//
// Build option:
//   UART_BAUD_FRAC_EN defined   -> fractional phase accumulator (NCO),
//                                  step INC, width ACC_WIDTH.
//   UART_BAUD_FRAC_EN undefined -> integer divider, step DIV.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  uart_baud_nco_if.slave (en, restart, baud_rate in;
//        os_tick, mid_tick, bit_tick, rate_err out)
module uart_baud_nco #(
   parameter int unsigned CLK_FREQ   = 150_000_000,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned ACC_WIDTH  = 24
) (
   input  logic           clk,
   input  logic           rst,
   uart_baud_nco_if.slave bus
);

   localparam int unsigned NRATES = 9;
   localparam logic [16:0] RATES [NRATES] = '{
      17'd1200, 17'd2400, 17'd4800, 17'd9600, 17'd14400,
      17'd19200, 17'd38400, 17'd57600, 17'd115200
   };
   localparam logic [16:0] DEFAULT_RATE = 17'd9600;
   localparam int unsigned OS_W = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

   // Out-of-range parameter sets report every rate as unsupported.
   localparam bit PARAMS_OK = (OVERSAMPLE % 2 == 0) && (OVERSAMPLE >= 4) &&
                              (OVERSAMPLE <= 64) && (ACC_WIDTH >= 16) &&
                              (ACC_WIDTH <= 32);

`ifdef UART_BAUD_FRAC_EN
   // INC = round(rate * OVERSAMPLE * 2^ACC_WIDTH / CLK_FREQ)
   function automatic longint unsigned calc_step(input logic [16:0] rate);
      longint unsigned r;
      longint unsigned num;
      r   = 64'(rate);
      num = r * OVERSAMPLE * (64'd1 << ACC_WIDTH);
      return (num + CLK_FREQ / 2) / CLK_FREQ;
   endfunction
   localparam int unsigned STEP_W = ACC_WIDTH;
`else
   // DIV = max(1, round(CLK_FREQ / (rate * OVERSAMPLE)))
   function automatic longint unsigned calc_step(input logic [16:0] rate);
      longint unsigned den;
      longint unsigned q;
      den = 64'(rate) * OVERSAMPLE;
      q   = (CLK_FREQ + den / 2) / den;
      return (q < 64'd1) ? 64'd1 : q;
   endfunction
   // 1200 baud has the largest divisor in the table.
   localparam int unsigned STEP_W = $clog2(calc_step(17'd1200) + 64'd1);
`endif

   localparam logic [STEP_W-1:0] STEP_DEFAULT = STEP_W'(calc_step(DEFAULT_RATE));

   logic [16:0]       baud_q;
   logic [STEP_W-1:0] step_tab [NRATES];
   logic [STEP_W-1:0] step;
   logic              rate_ok;
   logic              resync;
   // phase is the NCO accumulator (acc) or the divider count (div_cnt).
   logic [STEP_W-1:0] phase;
   logic [STEP_W-1:0] phase_next;
   logic              carry;
   logic [OS_W-1:0]   os_cnt;

   for (genvar g = 0; g < NRATES; g++) begin : g_step
      localparam logic [STEP_W-1:0] STEP_G = STEP_W'(calc_step(RATES[g]));
      assign step_tab[g] = STEP_G;
   end

   always_comb begin
      step    = STEP_DEFAULT;
      rate_ok = 1'b0;
      for (int unsigned i = 0; i < NRATES; i++) begin
         if (baud_q == RATES[i]) begin
            step    = step_tab[i];
            rate_ok = 1'b1;
         end
      end
   end

   // A rate change is detected against the held baud_q even while en=0.
   always_comb resync = bus.restart || (bus.baud_rate != baud_q);

`ifdef UART_BAUD_FRAC_EN
   always_comb {carry, phase_next} = {1'b0, phase} + {1'b0, step};
`else
   always_comb begin
      carry      = (phase == step - 1'b1);
      phase_next = carry ? '0 : phase + 1'b1;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_q       <= DEFAULT_RATE;
         phase        <= '0;
         os_cnt       <= '0;
         bus.os_tick  <= 1'b0;
         bus.mid_tick <= 1'b0;
         bus.bit_tick <= 1'b0;
         bus.rate_err <= 1'b0;
      end else begin
         bus.rate_err <= ~rate_ok | ~PARAMS_OK;
         if (bus.en) begin
            baud_q <= bus.baud_rate;
         end
         if (resync) begin
            phase        <= '0;
            os_cnt       <= '0;
            bus.os_tick  <= 1'b0;
            bus.mid_tick <= 1'b0;
            bus.bit_tick <= 1'b0;
         end else if (bus.en) begin
            phase <= phase_next;
            if (carry) begin
               os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
            end
            bus.os_tick  <= carry;
            bus.mid_tick <= carry && (os_cnt == OS_MID);
            bus.bit_tick <= carry && (os_cnt == OS_LAST);
         end else begin
            bus.os_tick  <= 1'b0;
            bus.mid_tick <= 1'b0;
            bus.bit_tick <= 1'b0;
         end
      end
   end

endmodule
